// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC, reads instruction memory combinationally
// and registers {valid, inst, pc, pcplus, inst_count, canary} into the FE latch.
module fetch_stage #(
  parameter int                        DBITS          = 32,
  parameter int                        IMEM_ADDR_BITS = 14,
  parameter logic [DBITS-1:0]          START_PC       = 32'h0000_0200,
  parameter int                        CANARY_WIDTH   = 4,
  parameter logic [CANARY_WIDTH-1:0]   CANARY_VALUE   = 4'hF
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      stall_DE,
  input  logic                                      redirect_AGEX,
  input  logic [DBITS-1:0]                          target_AGEX,
  output logic [IMEM_ADDR_BITS-1:0]                 imem_addr,
  input  logic [31:0]                               imem_rdata,
  output logic [1+32+3*DBITS+CANARY_WIDTH-1:0]      FE_latch_out,
  output logic                                      misalign_err
);

  localparam int LATCH_W = 1 + 32 + 3 * DBITS + CANARY_WIDTH;

  // Valid semantics: FE_latch_out[MSB]=1 marks a real instruction for decode;
  // decode holds it off with stall_DE, and a valid=0 word is a bubble with all fields zero.
  logic [DBITS-1:0]   pc;
  logic [DBITS-1:0]   inst_count;
  logic [LATCH_W-1:0] fe_latch;
  logic               misalign;
  logic [DBITS-1:0]   pc_plus4;
  logic [DBITS-1:0]   count_plus1;

  assign pc_plus4    = pc + DBITS'(4);
  assign count_plus1 = inst_count + DBITS'(1);

  assign imem_addr    = pc[IMEM_ADDR_BITS+1:2];
  assign FE_latch_out = fe_latch;
  assign misalign_err = misalign;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= START_PC;
      inst_count <= '0;
      fe_latch   <= '0;
      misalign   <= 1'b0;
    end else if (redirect_AGEX) begin
      // Redirect wins over stall: squash the wrong-path fetch and drop the low bits.
      pc       <= {target_AGEX[DBITS-1:2], 2'b00};
      fe_latch <= '0;
      misalign <= misalign | (|target_AGEX[1:0]);
    end else if (!stall_DE) begin
      pc         <= pc_plus4;
      inst_count <= count_plus1;
      fe_latch   <= {1'b1, imem_rdata, pc, pc_plus4, count_plus1, CANARY_VALUE};
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: linear sequence of steps with hand-computed latch,
// imem_addr and misalign_err expectations checked by immediate assertions.
module tb_fetch_stage;

  localparam int LW = 1 + 32 + 3 * 32 + 4;

  logic          clk;
  logic          reset;
  logic          stall_DE;
  logic          redirect_AGEX;
  logic [31:0]   target_AGEX;
  logic [13:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic [LW-1:0] FE_latch_out;
  logic          misalign_err;

  logic          nop_mode;
  int            n_checks;
  int            n_errors;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall_DE      (stall_DE),
    .redirect_AGEX (redirect_AGEX),
    .target_AGEX   (target_AGEX),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .FE_latch_out  (FE_latch_out),
    .misalign_err  (misalign_err)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: nop in the first phase, then an address-tagged word.
  assign imem_rdata = nop_mode ? 32'h0000_0013 : {18'h2A5A5, imem_addr};

  function automatic logic [31:0] inst_at(input logic [31:0] pc, input logic nop);
    logic [13:0] wa;
    wa = pc[15:2];
    return nop ? 32'h0000_0013 : {18'h2A5A5, wa};
  endfunction

  function automatic logic [LW-1:0] exp_latch(input logic [31:0] inst, input logic [31:0] pc,
                                               input logic [31:0] count);
    logic [31:0] pcplus;
    pcplus = pc + 32'd4;
    return {1'b1, inst, pc, pcplus, count, 4'hF};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic stall, input logic redir, input logic [31:0] tgt);
    reset         = rst;
    stall_DE      = stall;
    redirect_AGEX = redir;
    target_AGEX   = tgt;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    nop_mode = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    step();
    chk("reset_latch", FE_latch_out, '0);
    chk("reset_addr", LW'(imem_addr), LW'(14'h080));
    chk("reset_misalign", LW'(misalign_err), LW'(1'b0));

    // Free-running fetch
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("fetch_200", FE_latch_out, exp_latch(32'h13, 32'h200, 32'd1));
    chk("addr_204", LW'(imem_addr), LW'(14'h081));
    step();
    chk("fetch_204", FE_latch_out, exp_latch(32'h13, 32'h204, 32'd2));
    chk("addr_208", LW'(imem_addr), LW'(14'h082));

    // Stall four cycles: latch and PC frozen
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_latch", FE_latch_out, exp_latch(32'h13, 32'h204, 32'd2));
      chk("stall_addr", LW'(imem_addr), LW'(14'h082));
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("release_208", FE_latch_out, exp_latch(32'h13, 32'h208, 32'd3));

    // Redirect with simultaneous stall: bubble, then target
    nop_mode = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 32'h400);
    step();
    chk("redir_bubble", FE_latch_out, '0);
    chk("redir_addr", LW'(imem_addr), LW'(14'h100));
    chk("redir_misalign", LW'(misalign_err), LW'(1'b0));
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("target_400", FE_latch_out, exp_latch(inst_at(32'h400, 1'b0), 32'h400, 32'd4));
    step();
    chk("target_404", FE_latch_out, exp_latch(inst_at(32'h404, 1'b0), 32'h404, 32'd5));

    // Misaligned redirect: low bits dropped, sticky error
    drive(1'b0, 1'b0, 1'b1, 32'h402);
    step();
    chk("mis_bubble", FE_latch_out, '0);
    chk("mis_addr", LW'(imem_addr), LW'(14'h100));
    chk("mis_set", LW'(misalign_err), LW'(1'b1));
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mis_sticky", LW'(misalign_err), LW'(1'b1));
    end
    chk("mis_after10", FE_latch_out, exp_latch(inst_at(32'h424, 1'b0), 32'h424, 32'd15));

    // Wrap at the top of the address space
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    chk("top_bubble", FE_latch_out, '0);
    chk("top_addr", LW'(imem_addr), LW'(14'h3FFF));
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("top_fetch", FE_latch_out,
        {1'b1, inst_at(32'hFFFF_FFFC, 1'b0), 32'hFFFF_FFFC, 32'h0000_0000, 32'd16, 4'hF});
    chk("wrap_addr", LW'(imem_addr), LW'(14'h0000));
    step();
    chk("wrap_fetch", FE_latch_out, exp_latch(inst_at(32'h0, 1'b0), 32'h0, 32'd17));

    // Reset overrides a simultaneous stall and redirect
    drive(1'b1, 1'b1, 1'b1, 32'h803);
    step();
    chk("rst_latch", FE_latch_out, '0);
    chk("rst_addr", LW'(imem_addr), LW'(14'h080));
    chk("rst_misalign", LW'(misalign_err), LW'(1'b0));
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("rst_refetch", FE_latch_out, exp_latch(inst_at(32'h200, 1'b0), 32'h200, 32'd1));

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
